// File: rtl/clk_meter.sv
// Clock measurement block: synchronizes an asynchronous clock-like input and
// reports the high time, low time and period of each complete cycle in
// system-clock cycles, with saturation flags for stuck or very slow inputs.
module clk_meter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic [CNT_W:0]   period_cnt,
  output logic             meas_valid,
  output logic             overflow,
  output logic             stalled
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StHigh, StLow} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] lcnt_q, lcnt_d;
  logic             sat_q, sat_d;
  logic             s1_q, s_q, sd_q;
  logic             rise, fall;
  logic             report;
  logic [CNT_W-1:0] hcnt_inc, lcnt_inc;

  // Two-flop synchronizer plus edge-detect register; runs regardless of enable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s_q  <= 1'b0;
      sd_q <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s_q  <= s1_q;
      sd_q <= s_q;
    end
  end

  assign rise = s_q & ~sd_q;
  assign fall = ~s_q & sd_q;

  // Saturating increments: counters stick at all-ones instead of wrapping.
  assign hcnt_inc = (hcnt_q == CntMax) ? hcnt_q : hcnt_q + CntOne;
  assign lcnt_inc = (lcnt_q == CntMax) ? lcnt_q : lcnt_q + CntOne;

  // Next-state and counter update; enable low overrides everything.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    lcnt_d  = lcnt_q;
    sat_d   = sat_q;
    report  = 1'b0;
    if (!enable) begin
      state_d = StIdle;
      hcnt_d  = '0;
      lcnt_d  = '0;
      sat_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // First partial phase is never measured: only a rise arms the meter.
          hcnt_d = '0;
          lcnt_d = '0;
          sat_d  = 1'b0;
          if (rise) begin
            state_d = StHigh;
            hcnt_d  = CntOne;
          end
        end
        StHigh: begin
          if (fall) begin
            state_d = StLow;
            lcnt_d  = CntOne;
          end else begin
            hcnt_d = hcnt_inc;
            sat_d  = sat_q | (hcnt_inc == CntMax);
          end
        end
        StLow: begin
          if (rise) begin
            report  = 1'b1;
            state_d = StHigh;
            hcnt_d  = CntOne;
            lcnt_d  = '0;
            sat_d   = 1'b0;
          end else begin
            lcnt_d = lcnt_inc;
            sat_d  = sat_q | (lcnt_inc == CntMax);
          end
        end
        default: begin
          state_d = StIdle;
          hcnt_d  = '0;
          lcnt_d  = '0;
          sat_d   = 1'b0;
        end
      endcase
    end
  end

  // FSM state and running counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      hcnt_q  <= '0;
      lcnt_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      lcnt_q  <= lcnt_d;
      sat_q   <= sat_d;
    end
  end

  // Result registers: latched on each completed period, held otherwise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      high_cnt   <= '0;
      low_cnt    <= '0;
      period_cnt <= '0;
      overflow   <= 1'b0;
      meas_valid <= 1'b0;
    end else begin
      meas_valid <= report;
      if (report) begin
        high_cnt   <= hcnt_q;
        low_cnt    <= lcnt_q;
        period_cnt <= {1'b0, hcnt_q} + {1'b0, lcnt_q};
        overflow   <= sat_q;
      end
    end
  end

  assign stalled = ((state_q == StHigh) && (hcnt_q == CntMax)) ||
                   ((state_q == StLow)  && (lcnt_q == CntMax));

endmodule

// File: doc/clk_meter.md
# clk_meter

Clock measurement block: the receive-side counterpart of the team's clock generators. It samples an asynchronous clock-like input with the system clock and measures its high time, low time and period in system-clock cycles. It reports each complete cycle with a one-cycle valid pulse, and flags counter saturation for stuck or too-slow inputs. It sits in testbenches and self-check logic next to generated clocks (e.g. the 1 MHz / 2 MHz / 30 %-duty sources) to confirm their frequency and duty cycle.

## Interface
- CNT_W, 16, width of high/low counters; period is CNT_W+1 bits
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- enable  in  1  measurement enable; low forces IDLE
- sig_in  in  1  asynchronous signal under measurement
- high_cnt  out  CNT_W  cycles sig high in last complete period
- low_cnt  out  CNT_W  cycles sig low in last complete period
- period_cnt  out  CNT_W+1  high_cnt + low_cnt of same period
- meas_valid  out  1  one-cycle pulse when the three counts update
- overflow  out  1  set with meas_valid if either count saturated in that period
- stalled  out  1  level: current high or low phase counter is saturated

## Operation
- Synchronizer: two flops, s1 <= sig_in, s <= s1; edge reg s_d <= s. rise = s & ~s_d, fall = ~s & s_d.
- Running counters hcnt, lcnt (CNT_W), sticky sat bit; increments saturate at all-ones (never wrap). Reaching all-ones sets sat.
- FSM states IDLE, HIGH, LOW:
  - IDLE: hcnt = lcnt = 0, sat = 0. On rise: go HIGH, hcnt <= 1. Fall or steady level is ignored, so the first partial phase is never measured.
  - HIGH: if fall, go LOW and set lcnt <= 1; else hcnt <= sat_inc(hcnt).
  - LOW: if rise, latch high_cnt <= hcnt, low_cnt <= lcnt, period_cnt <= hcnt + lcnt (full CNT_W+1 add, no saturation), overflow <= sat. Pulse meas_valid, then go HIGH with hcnt <= 1, lcnt <= 0, sat <= 0. Else lcnt <= sat_inc(lcnt).
- stalled = (state HIGH and hcnt all-ones) or (state LOW and lcnt all-ones); combinational from registers.
- enable low: FSM to IDLE next edge and counters cleared. The synchronizer keeps running. high_cnt/low_cnt/period_cnt/overflow hold their last values; meas_valid = 0.
- enable re-asserted: measurement restarts from IDLE (first rise only arms).

## Timing
- Reset (async assert, sync release use): state IDLE, s1 = s = s_d = 0, all outputs 0.
- Latency: sig_in high sampled at edge E0 -> s = 1 after E1 -> rise seen during cycle E1–E2 -> meas_valid high for the cycle after E2. Counts reflect synchronized level, so each measured phase is exact in cycles, ±1 for async input jitter.
- meas_valid is exactly one cycle wide; back-to-back pulses are legal for a 2-cycle period (high 1, low 1).
- Input phases shorter than one clock cycle may be lost; no requirement beyond not hanging.
- reset asserted mid-period: immediate return to reset values, no partial report.
- rise in same cycle enable drops: enable wins, no meas_valid.

## Test plan
- Reset: assert reset with sig_in toggling -> all outputs 0, no meas_valid while reset is high or before two full edges after release.
- Duty: sig_in high 3 / low 7 cycles, phase-aligned, repeated 5 periods -> first meas_valid after second rise, high_cnt=3, low_cnt=7, period_cnt=10, overflow=0, one pulse per period.
- Fast: sig_in toggling every cycle (high 1 / low 1) -> meas_valid every 2 cycles, high_cnt=1, low_cnt=1, period_cnt=2.
- Stuck: CNT_W=4, sig_in rises then stays high 20 cycles -> stalled=1 once hcnt=15. After fall + 2 low + rise: high_cnt=15, low_cnt=2, period_cnt=17, overflow=1, stalled=0.
- Enable: drop enable mid LOW phase of 5/5 signal -> no meas_valid, outputs hold 5/5/10. Re-enable -> first new report only after one full period.
- Async reset mid-HIGH -> outputs 0 within the same cycle. After release, the 4/4 signal reports 4/4/8 on its second rise.
